rc4_core_scheduler: RTL and testbench
=====================================

Name: rc4_core_scheduler

Overview:
Sequences a bank of NUM_CORES RC4 decrypt cores across a key range [key_base, key_limit] and dispatches one 22-bit key candidate per free core. It collects per-core done/valid results, stops every core on the first valid decryption and reports the cracked key. It sits between the top-level key-range control (switch/host) and the replicated decrypt cores. Per-core counter stepping is replaced by central dispatch.

Parameters:
NUM_CORES, 4, number of decrypt cores scheduled (1..16)
KEY_W, 22, key candidate width in bits

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; latches range and begins search; ignored unless state is IDLE, FOUND or EXHAUSTED
key_base  input  KEY_W  first key to try; sampled on start
key_limit  input  KEY_W  last key to try, inclusive; sampled on start
core_done  input  NUM_CORES  per-core one-cycle pulse: decryption of the assigned key finished
core_valid  input  NUM_CORES  per-core result; meaningful only in the cycle its core_done is high
core_start  output  NUM_CORES  per-core one-cycle pulse: begin decrypting core_key[i]
core_key  output  NUM_CORES*KEY_W  per-core assigned key; slice i is bits [i*KEY_W +: KEY_W]; held stable while core i is busy
core_abort  output  1  one-cycle pulse to all cores when a key is found
busy  output  1  high in RUN and DRAIN
found  output  1  sticky; high in FOUND
exhausted  output  1  sticky; high in EXHAUSTED
found_key  output  KEY_W  key that produced the valid result
keys_tried  output  KEY_W+1  count of completed core results (done pulses accepted) since the last start

Behaviour:
- Reset: state IDLE and all outputs 0. Internal next_key is 0, core_busy is all 0, and the rr pointer is 0. Reset mid-search drops everything immediately. Cores must also be reset by the same rst.
- next_key is KEY_W+1 bits wide, so incrementing past 2^KEY_W-1 cannot wrap. Range is empty once next_key > {1'b0,key_limit}.
- States:
  - IDLE: on start, latch the range, set next_key=key_base, clear keys_tried/found/exhausted/found_key, and go to RUN. If key_base > key_limit, go directly to EXHAUSTED instead.
  - RUN: in each cycle, if any core is free and the range is not empty, dispatch exactly one core. The chosen core is the first free index at or after rr_ptr, searching circularly. Dispatch registers core_key[i]=next_key and pulses core_start[i] in the next cycle; it also sets core_busy[i], increments next_key and sets rr_ptr=i+1 mod NUM_CORES. When the range becomes empty, go to DRAIN.
  - DRAIN: dispatch nothing; wait for the busy cores to finish. When core_busy is all 0, go to EXHAUSTED.
  - FOUND / EXHAUSTED: terminal until the next start, which behaves as from IDLE. In these states core_start stays 0 and core_done is ignored.
- Result handling, applies in RUN and DRAIN:
  - Each core_done[i] with core_busy[i] set clears core_busy[i] and increments keys_tried.
  - A core_done on a non-busy core is ignored.
  - A core freed in cycle T is eligible for dispatch no earlier than cycle T+1.
- Valid result:
  - If any accepted done has valid=1, go to FOUND. found_key is the key of the lowest-index core with done&valid in that cycle.
  - Pulse core_abort for one cycle, clear core_busy, and set found=1 on the same edge.
  - A valid result takes priority over range-empty and over the DRAIN→EXHAUSTED transition in the same cycle.
- Latency: start at edge T gives the first core_start visible after edge T+1. Done&valid at edge T gives found=1 after edge T+1.
- At most one core_start bit is high per cycle. core_start and core_abort are never high together.

Decomposition:
- Package rc4_sched_pkg holds:
  - state enum: IDLE, RUN, DRAIN, FOUND, EXHAUSTED
  - KEY_W default
  - key_t typedef
- One sub-module, rr_free_picker: combinational circular priority encoder. Inputs are core_busy and rr_ptr; outputs are grant index and grant_valid. All sequencing stays in the top module.

Test Plan:
- Range 0x000010..0x000013, NUM_CORES=4, every core returns done with valid=0 after 5 cycles -> core_start goes to cores 0,1,2,3 on consecutive cycles with keys 0x10..0x13; exhausted=1 and keys_tried=4; found=0.
- Range 0x000000..0x000009, core 2 returns valid for key 0x000002 -> core_abort pulses once, found=1, found_key=0x000002 and busy=0; no core_start after the abort.
- Cores 1 and 3 report done&valid in the same cycle with keys 0x21 and 0x23 -> found_key=0x21.
- Range 0x3FFFFE..0x3FFFFF -> exactly 2 dispatches and no wrap to 0x000000; exhausted=1 and keys_tried=2.
- key_base=0x000100 > key_limit=0x0000FF -> exhausted=1 one cycle after start; core_start never asserts.
- Assert rst while 3 cores are busy, then start a new range 0x50..0x51 -> all outputs are 0 during reset; after start, keys 0x50 and 0x51 go to cores 0 and 1, and stale core_done pulses on non-busy cores are ignored with keys_tried unchanged.

Source files
------------

// File: rtl/rc4_sched_pkg.sv
// Shared types for the RC4 core scheduler.
//   KEY_W_DEFAULT : default key candidate width
//   key_t         : key candidate at the default width
//   state_e       : scheduler FSM states
package rc4_sched_pkg;

    localparam int unsigned KEY_W_DEFAULT = 22;

    typedef logic [KEY_W_DEFAULT-1:0] key_t;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StFound,
        StExhausted
    } state_e;

endpackage

// File: rtl/rr_free_picker.sv
// Circular priority encoder: picks the first non-busy core at or after rr_ptr.
//   core_busy   : per-core busy flags
//   rr_ptr      : index where the circular search starts
//   grant_idx   : chosen free core (valid only with grant_valid)
//   grant_valid : at least one core is free
module rr_free_picker #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] core_busy,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] idx_l;
        idx         = 0;
        idx_l       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned off = 0; off < NUM_CORES; off++) begin
            idx   = (32'(rr_ptr) + off) % NUM_CORES;
            idx_l = IDX_W'(idx);
            if (!grant_valid && !core_busy[idx_l]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_l;
            end
        end
    end

endmodule

// File: rtl/rc4_core_scheduler.sv
// Central key dispatcher for a bank of RC4 decrypt cores. Hands out one key per
// cycle to a free core over [key_base, key_limit], collects done/valid results,
// aborts every core on the first valid result and reports the cracked key.
//   start/key_base/key_limit : range control from host
//   core_done/core_valid     : per-core results
//   core_start/core_key      : per-core dispatch (key held while core is busy)
//   core_abort               : broadcast stop on success
//   busy/found/exhausted     : status; found_key and keys_tried report results
module rc4_core_scheduler
    import rc4_sched_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned KEY_W     = KEY_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [KEY_W-1:0]           key_base,
    input  logic [KEY_W-1:0]           key_limit,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_valid,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*KEY_W-1:0] core_key,
    output logic                       core_abort,
    output logic                       busy,
    output logic                       found,
    output logic                       exhausted,
    output logic [KEY_W-1:0]           found_key,
    output logic [KEY_W:0]             keys_tried
);

    localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef logic [KEY_W:0] cnt_t;

    state_e                     state_q, state_d;
    cnt_t                       next_key_q, next_key_d;
    logic [KEY_W-1:0]           limit_q, limit_d;
    logic [NUM_CORES-1:0]       core_busy_q, core_busy_d;
    logic [IdxW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES*KEY_W-1:0] core_key_q, core_key_d;
    logic [NUM_CORES-1:0]       core_start_q, core_start_d;
    logic                       core_abort_q, core_abort_d;
    logic                       found_q, found_d;
    logic                       exhausted_q, exhausted_d;
    logic [KEY_W-1:0]           found_key_q, found_key_d;
    cnt_t                       keys_tried_q, keys_tried_d;

    logic [IdxW-1:0] grant_idx;
    logic            grant_valid;

    rr_free_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IdxW)
    ) u_picker (
        .core_busy   (core_busy_q),
        .rr_ptr      (rr_ptr_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        logic [NUM_CORES-1:0] accepted;
        logic [NUM_CORES-1:0] hit;
        logic                 hit_seen;
        logic [KEY_W-1:0]     hit_key;
        cnt_t                 n_acc;

        state_d      = state_q;
        next_key_d   = next_key_q;
        limit_d      = limit_q;
        core_busy_d  = core_busy_q;
        rr_ptr_d     = rr_ptr_q;
        core_key_d   = core_key_q;
        core_start_d = '0;
        core_abort_d = 1'b0;
        found_d      = found_q;
        exhausted_d  = exhausted_q;
        found_key_d  = found_key_q;
        keys_tried_d = keys_tried_q;

        // Done pulses from idle cores (stale or spurious) are dropped here.
        accepted = core_done & core_busy_q;
        hit      = accepted & core_valid;
        hit_seen = 1'b0;
        hit_key  = '0;
        n_acc    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (accepted[i]) begin
                n_acc = n_acc + cnt_t'(1);
            end
            if (hit[i] && !hit_seen) begin
                hit_seen = 1'b1;
                hit_key  = core_key_q[i*KEY_W +: KEY_W];
            end
        end

        case (state_q)
            StIdle, StFound, StExhausted: begin
                if (start) begin
                    limit_d      = key_limit;
                    next_key_d   = {1'b0, key_base};
                    keys_tried_d = '0;
                    found_d      = 1'b0;
                    exhausted_d  = 1'b0;
                    found_key_d  = '0;
                    if (key_base > key_limit) begin
                        state_d     = StExhausted;
                        exhausted_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun, StDrain: begin
                core_busy_d  = core_busy_q & ~accepted;
                keys_tried_d = keys_tried_q + n_acc;
                if (hit_seen) begin
                    // Success wins over dispatch, range-empty and drain completion.
                    state_d      = StFound;
                    found_d      = 1'b1;
                    found_key_d  = hit_key;
                    core_abort_d = 1'b1;
                    core_busy_d  = '0;
                end else if (state_q == StRun) begin
                    // Picker sees the pre-clear busy mask, so a core freed this
                    // cycle is only reused from the next cycle on.
                    if (grant_valid && (next_key_q <= {1'b0, limit_q})) begin
                        core_key_d[grant_idx*KEY_W +: KEY_W] = next_key_q[KEY_W-1:0];
                        core_start_d[grant_idx]              = 1'b1;
                        core_busy_d[grant_idx]               = 1'b1;
                        next_key_d                           = next_key_q + cnt_t'(1);
                        rr_ptr_d = (32'(grant_idx) == NUM_CORES - 1) ? '0
                                                                      : grant_idx + IdxW'(1);
                    end
                    if (next_key_d > {1'b0, limit_q}) begin
                        state_d = StDrain;
                    end
                end else if (core_busy_q == '0) begin
                    state_d     = StExhausted;
                    exhausted_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            next_key_q   <= '0;
            limit_q      <= '0;
            core_busy_q  <= '0;
            rr_ptr_q     <= '0;
            core_key_q   <= '0;
            core_start_q <= '0;
            core_abort_q <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            found_key_q  <= '0;
            keys_tried_q <= '0;
        end else begin
            state_q      <= state_d;
            next_key_q   <= next_key_d;
            limit_q      <= limit_d;
            core_busy_q  <= core_busy_d;
            rr_ptr_q     <= rr_ptr_d;
            core_key_q   <= core_key_d;
            core_start_q <= core_start_d;
            core_abort_q <= core_abort_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            found_key_q  <= found_key_d;
            keys_tried_q <= keys_tried_d;
        end
    end

    assign core_start = core_start_q;
    assign core_key   = core_key_q;
    assign core_abort = core_abort_q;
    assign busy       = (state_q == StRun) || (state_q == StDrain);
    assign found      = found_q;
    assign exhausted  = exhausted_q;
    assign found_key  = found_key_q;
    assign keys_tried = keys_tried_q;

endmodule

// File: tb/tb_rc4_core_scheduler.sv
// Bench for rc4_core_scheduler: emulates the decrypt cores (fixed per-core
// latency, valid when the key matches a secret) and checks dispatch order,
// key sequence and final status against expectations from the key range.
module tb_rc4_core_scheduler;
    import rc4_sched_pkg::*;

    localparam int unsigned NC = 4;
    localparam int unsigned KW = KEY_W_DEFAULT;
    localparam logic [KW:0] NoSecret = {(KW+1){1'b1}};

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    key_t             key_base;
    key_t             key_limit;
    logic [NC-1:0]    core_done;
    logic [NC-1:0]    core_valid;
    logic [NC-1:0]    core_start;
    logic [NC*KW-1:0] core_key;
    logic             core_abort;
    logic             busy;
    logic             found;
    logic             exhausted;
    key_t             found_key;
    logic [KW:0]      keys_tried;

    always #5 clk = ~clk;

    rc4_core_scheduler #(
        .NUM_CORES (NC),
        .KEY_W     (KW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_base   (key_base),
        .key_limit  (key_limit),
        .core_done  (core_done),
        .core_valid (core_valid),
        .core_start (core_start),
        .core_key   (core_key),
        .core_abort (core_abort),
        .busy       (busy),
        .found      (found),
        .exhausted  (exhausted),
        .found_key  (found_key),
        .keys_tried (keys_tried)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    always @(posedge clk) cycle++;

    // Written only by the initial block.
    int          lat [NC];
    logic [KW:0] secret_a;
    logic [KW:0] secret_b;
    logic [KW:0] scen_base;
    logic        clear_req;
    logic [NC-1:0] stale_mask;

    // Core model / monitor state, written only by the negedge process.
    logic        pend [NC];
    int          cnt [NC];
    key_t        pend_key [NC];
    logic [KW:0] exp_next;
    int starts, dones_sent, aborts, starts_after_abort;
    int viol_multi, viol_abort_start, viol_key, viol_busy, viol_stable;
    logic abort_seen, valid_seen;
    key_t model_fk;
    int start_core[$];
    int start_cyc[$];

    function automatic logic is_secret(input key_t k);
        return ({1'b0, k} == secret_a) || ({1'b0, k} == secret_b);
    endfunction

    always @(negedge clk) begin
        logic [NC-1:0] d;
        logic [NC-1:0] v;
        key_t k;
        d = '0;
        v = '0;
        if (clear_req) begin
            exp_next = scen_base;
            starts = 0; dones_sent = 0; aborts = 0; starts_after_abort = 0;
            viol_multi = 0; viol_abort_start = 0; viol_key = 0; viol_busy = 0;
            viol_stable = 0; abort_seen = 1'b0; valid_seen = 1'b0; model_fk = '0;
            start_core.delete();
            start_cyc.delete();
        end
        if (rst) begin
            for (int i = 0; i < NC; i++) pend[i] = 1'b0;
        end else begin
            if ($countones(core_start) > 1) viol_multi++;
            if ((|core_start) && core_abort) viol_abort_start++;
            if (core_abort) begin
                aborts++;
                abort_seen = 1'b1;
                for (int i = 0; i < NC; i++) pend[i] = 1'b0;
            end
            for (int i = 0; i < NC; i++) begin
                if (pend[i]) begin
                    k = core_key[i*KW +: KW];
                    if (k != pend_key[i]) viol_stable++;
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        pend[i] = 1'b0;
                        d[i] = 1'b1;
                        v[i] = is_secret(pend_key[i]);
                        dones_sent++;
                    end
                end
            end
            if ((|v) && !valid_seen) begin
                valid_seen = 1'b1;
                for (int i = NC - 1; i >= 0; i--) begin
                    if (v[i]) model_fk = pend_key[i];
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    k = core_key[i*KW +: KW];
                    starts++;
                    if (abort_seen) starts_after_abort++;
                    if (pend[i]) viol_busy++;
                    if ({1'b0, k} != exp_next) viol_key++;
                    exp_next = exp_next + 1'b1;
                    start_core.push_back(i);
                    start_cyc.push_back(cycle);
                    pend[i] = 1'b1;
                    pend_key[i] = k;
                    cnt[i] = lat[i];
                end
            end
            d = d | stale_mask;
            v = v | stale_mask;
        end
        core_done  = d;
        core_valid = v;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int core_at(input int k);
        if (k < start_core.size()) return start_core[k];
        return -1;
    endfunction

    function automatic int cyc_at(input int k);
        if (k < start_cyc.size()) return start_cyc[k];
        return -1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Pulses start for one cycle; returns with the start already sampled.
    task automatic launch(input key_t b, input key_t l, output int t0);
        scen_base = {1'b0, b};
        clear_req = 1'b1;
        key_base  = b;
        key_limit = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
        clear_req = 1'b0;
        t0        = cycle;
    endtask

    task automatic wait_end(input int budget, input string tag);
        int n;
        n = 0;
        while (!(found || exhausted) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_terminated"}, 64'(found || exhausted), 64'd1);
    endtask

    task automatic chk_clean(input string tag);
        chk({tag, "_multi_start"}, 64'(viol_multi), 64'd0);
        chk({tag, "_start_with_abort"}, 64'(viol_abort_start), 64'd0);
        chk({tag, "_key_seq"}, 64'(viol_key), 64'd0);
        chk({tag, "_start_busy"}, 64'(viol_busy), 64'd0);
        chk({tag, "_key_stable"}, 64'(viol_stable), 64'd0);
    endtask

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; key_base = '0; key_limit = '0;
        stale_mask = '0; clear_req = 1'b1; scen_base = '0;
        secret_a = NoSecret; secret_b = NoSecret;
        for (int i = 0; i < NC; i++) lat[i] = 5;
        step();
        step();
        chk("reset_outputs", 64'({core_start, core_abort, busy, found, exhausted, found_key,
                                  keys_tried}), 64'd0);
        chk("reset_core_key", 64'(core_key), 64'd0);
        rst = 1'b0;
        clear_req = 1'b0;
        step();

        // T1: 4 keys, no valid result
        launch(22'h000010, 22'h000013, t0);
        wait_end(200, "t1");
        chk("t1_exhausted", 64'(exhausted), 64'd1);
        chk("t1_found", 64'(found), 64'd0);
        chk("t1_keys_tried", 64'(keys_tried), 64'd4);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_starts", 64'(starts), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_core_order%0d", k), 64'(core_at(k)), 64'(k));
            chk($sformatf("t1_start_cycle%0d", k), 64'(cyc_at(k) - t0), 64'(k + 1));
        end
        chk_clean("t1");

        // T2: key 2 is valid
        apply_reset();
        secret_a = 23'h000002;
        launch(22'h000000, 22'h000009, t0);
        wait_end(200, "t2");
        step();
        step();
        step();
        chk("t2_found", 64'(found), 64'd1);
        chk("t2_exhausted", 64'(exhausted), 64'd0);
        chk("t2_found_key", 64'(found_key), 64'h2);
        chk("t2_busy", 64'(busy), 64'd0);
        chk("t2_keys_tried", 64'(keys_tried), 64'd3);
        chk("t2_keys_tried_model", 64'(keys_tried), 64'(dones_sent));
        chk("t2_abort_pulses", 64'(aborts), 64'd1);
        chk("t2_start_after_abort", 64'(starts_after_abort), 64'd0);
        chk_clean("t2");

        // T3: cores 1 and 3 valid in the same cycle
        apply_reset();
        lat[0] = 10; lat[1] = 6; lat[2] = 10; lat[3] = 4;
        secret_a = 23'h000021;
        secret_b = 23'h000023;
        launch(22'h000020, 22'h000023, t0);
        wait_end(200, "t3");
        chk("t3_found", 64'(found), 64'd1);
        chk("t3_found_key", 64'(found_key), 64'h21);
        chk("t3_found_key_model", 64'(found_key), 64'(model_fk));
        chk("t3_keys_tried", 64'(keys_tried), 64'd2);

        // T4: top of key space, no wrap
        secret_a = NoSecret;
        secret_b = NoSecret;
        for (int i = 0; i < NC; i++) lat[i] = 3;
        launch(22'h3FFFFE, 22'h3FFFFF, t0);
        wait_end(200, "t4");
        for (int i = 0; i < 5; i++) step();
        chk("t4_starts", 64'(starts), 64'd2);
        chk("t4_exhausted", 64'(exhausted), 64'd1);
        chk("t4_found", 64'(found), 64'd0);
        chk("t4_keys_tried", 64'(keys_tried), 64'd2);
        chk_clean("t4");

        // T5: empty range
        launch(22'h000100, 22'h0000FF, t0);
        chk("t5_exhausted_next_cycle", 64'(exhausted), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) step();
        chk("t5_starts", 64'(starts), 64'd0);
        chk("t5_keys_tried", 64'(keys_tried), 64'd0);

        // T6: reset while 3 cores busy, then fresh range with stale dones
        for (int i = 0; i < NC; i++) lat[i] = 20;
        launch(22'h000030, 22'h00003F, t0);
        for (int i = 0; i < 20 && starts < 3; i++) step();
        chk("t6_three_busy", 64'(starts >= 3), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_reset_outputs", 64'({core_start, core_abort, busy, found, exhausted, found_key,
                                     keys_tried}), 64'd0);
        chk("t6_reset_core_key", 64'(core_key), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < NC; i++) lat[i] = 3;
        launch(22'h000050, 22'h000051, t0);
        step();
        step();
        stale_mask = 4'b1100;
        step();
        stale_mask = '0;
        wait_end(200, "t6");
        chk("t6_core0", 64'(core_at(0)), 64'd0);
        chk("t6_core1", 64'(core_at(1)), 64'd1);
        chk("t6_starts", 64'(starts), 64'd2);
        chk("t6_keys_tried", 64'(keys_tried), 64'd2);
        chk("t6_found", 64'(found), 64'd0);
        chk("t6_exhausted", 64'(exhausted), 64'd1);
        chk_clean("t6");

        // Randomized ranges, latencies and secret placement
        for (int n = 0; n < 6; n++) begin
            key_t b;
            key_t l;
            int   len;
            string tg;
            tg  = $sformatf("rnd%0d", n);
            for (int i = 0; i < NC; i++) lat[i] = int'($urandom_range(1, 8));
            b   = key_t'($urandom_range(0, 32'h3FFF00));
            len = int'($urandom_range(1, 24));
            l   = b + key_t'(len - 1);
            if ($urandom_range(0, 1) == 1) begin
                secret_a = {1'b0, b} + 23'($urandom_range(0, len - 1));
            end else begin
                secret_a = NoSecret;
            end
            secret_b = NoSecret;
            launch(b, l, t0);
            wait_end(400, tg);
            if (secret_a != NoSecret) begin
                chk({tg, "_found"}, 64'(found), 64'd1);
                chk({tg, "_found_key"}, 64'(found_key), 64'(secret_a));
                chk({tg, "_keys_tried"}, 64'(keys_tried), 64'(dones_sent));
            end else begin
                chk({tg, "_exhausted"}, 64'(exhausted), 64'd1);
                chk({tg, "_keys_tried"}, 64'(keys_tried), 64'(len));
                chk({tg, "_starts"}, 64'(starts), 64'(len));
            end
            step();
            step();
            chk({tg, "_start_after_abort"}, 64'(starts_after_abort), 64'd0);
            chk_clean(tg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
